// File: rtl/hazard_ctl_pkg.sv
// Shared hazard/forwarding definitions: forward-select encoding and the shadow-slot layout.
// The datapath forwarding mux imports the same encoding.
package hazard_ctl_pkg;

    localparam int HZ_REG_AW = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_ACC = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [HZ_REG_AW-1:0] rd;
        logic                 we;
        logic                 is_load;
    } hz_slot_t;

    localparam int SLOT_W = $bits(hz_slot_t);

    // x0 is hardwired zero, so a producer targeting it never supplies a value.
    function automatic logic slot_hit(input hz_slot_t s, input logic [HZ_REG_AW-1:0] src,
                                      input logic use_src);
        return s.valid && s.we && (s.rd == src) && (src != '0) && use_src;
    endfunction

endpackage

// File: rtl/hazard_ctl_fwd_sel.sv
// Single-operand forwarding priority compare: the youngest matching producer wins (E > M > W).
module hazard_fwd_sel
    import hazard_ctl_pkg::*;
(
    input  logic [HZ_REG_AW-1:0] i_src,
    input  logic                 i_use,
    input  logic [SLOT_W-1:0]    i_slot_e,
    input  logic [SLOT_W-1:0]    i_slot_m,
    input  logic [SLOT_W-1:0]    i_slot_w,
    output logic [1:0]           o_sel,
    output logic                 o_hit_e
);

    hz_slot_t w_e, w_m, w_w;
    logic     w_hit_m, w_hit_w;

    assign w_e = hz_slot_t'(i_slot_e);
    assign w_m = hz_slot_t'(i_slot_m);
    assign w_w = hz_slot_t'(i_slot_w);

    assign o_hit_e = slot_hit(w_e, i_src, i_use);
    assign w_hit_m = slot_hit(w_m, i_src, i_use);
    assign w_hit_w = slot_hit(w_w, i_src, i_use);

    always_comb begin
        o_sel = FWD_REG;
        if (o_hit_e)      o_sel = FWD_EX;
        else if (w_hit_m) o_sel = FWD_ACC;
        else if (w_hit_w) o_sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: shadow of E/M/W destinations, forwarding, load-use stall,
// redirect flush and memory freeze. Optional perf counters under `HAZARD_PERF_EN.
module hazard_ctl
    import hazard_ctl_pkg::*;
#(
    parameter int REG_AW = HZ_REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              de_valid,
    input  logic [REG_AW-1:0] de_rs1,
    input  logic [REG_AW-1:0] de_rs2,
    input  logic              de_use_rs1,
    input  logic              de_use_rs2,
    input  logic [REG_AW-1:0] de_rd,
    input  logic              de_reg_we,
    input  logic              de_is_load,
    input  logic              ex_redirect,
    input  logic              mem_stall_req,
    output logic              stall_pc,
    output logic              stall_de,
    output logic              bubble_ex,
    output logic              flush_de,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt,
    output logic [CNT_W-1:0]  perf_freeze_cnt
`endif
);

    // Empty guard block: keeps CNT_W referenced in builds without the counters.
    if (CNT_W < 1) begin : g_cnt_w_invalid
    end

    hz_slot_t   r_slot_e, r_slot_m, r_slot_w;
    hz_slot_t   w_slot_new;
    logic [1:0] w_sel_a, w_sel_b;
    logic       w_hit_e_a, w_hit_e_b;
    logic       w_load_use, w_issue;
    logic       w_lu_stall, w_flush;

    hazard_fwd_sel u_fwd_a (
        .i_src    (HZ_REG_AW'(de_rs1)),
        .i_use    (de_use_rs1),
        .i_slot_e (r_slot_e),
        .i_slot_m (r_slot_m),
        .i_slot_w (r_slot_w),
        .o_sel    (w_sel_a),
        .o_hit_e  (w_hit_e_a)
    );

    hazard_fwd_sel u_fwd_b (
        .i_src    (HZ_REG_AW'(de_rs2)),
        .i_use    (de_use_rs2),
        .i_slot_e (r_slot_e),
        .i_slot_m (r_slot_m),
        .i_slot_w (r_slot_w),
        .o_sel    (w_sel_b),
        .o_hit_e  (w_hit_e_b)
    );

    assign w_load_use = de_valid && (w_hit_e_a || w_hit_e_b) && r_slot_e.is_load;
    assign w_issue    = de_valid && !w_load_use && !ex_redirect;
    assign w_lu_stall = !mem_stall_req && !ex_redirect && w_load_use;
    assign w_flush    = !mem_stall_req && ex_redirect;

    always_comb begin
        w_slot_new         = '0;
        w_slot_new.valid   = w_issue;
        w_slot_new.rd      = HZ_REG_AW'(de_rd);
        w_slot_new.we      = de_reg_we;
        w_slot_new.is_load = de_is_load;
    end

    // Freeze beats redirect beats load-use; reset silences everything.
    always_comb begin
        stall_pc  = 1'b0;
        stall_de  = 1'b0;
        bubble_ex = 1'b0;
        flush_de  = 1'b0;
        fwd_a_sel = FWD_REG;
        fwd_b_sel = FWD_REG;
        if (!rst) begin
            fwd_a_sel = w_sel_a;
            fwd_b_sel = w_sel_b;
            if (mem_stall_req) begin
                stall_pc = 1'b1;
                stall_de = 1'b1;
            end else if (ex_redirect) begin
                flush_de  = 1'b1;
                bubble_ex = 1'b1;
            end else if (w_load_use) begin
                stall_pc  = 1'b1;
                stall_de  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_e.valid <= 1'b0;
            r_slot_m.valid <= 1'b0;
            r_slot_w.valid <= 1'b0;
        end else if (!mem_stall_req) begin
            r_slot_w <= r_slot_m;
            r_slot_m <= r_slot_e;
            r_slot_e <= w_slot_new;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_freeze_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else begin
            if (w_lu_stall && (r_stall_cnt != '1))     r_stall_cnt  <= r_stall_cnt + 1'b1;
            if (w_flush && (r_flush_cnt != '1))        r_flush_cnt  <= r_flush_cnt + 1'b1;
            if (mem_stall_req && (r_freeze_cnt != '1)) r_freeze_cnt <= r_freeze_cnt + 1'b1;
        end
    end

    assign perf_stall_cnt  = r_stall_cnt;
    assign perf_flush_cnt  = r_flush_cnt;
    assign perf_freeze_cnt = r_freeze_cnt;
`else
    logic w_unused_perf;
    assign w_unused_perf = ^{w_lu_stall, w_flush};
`endif

endmodule

// File: doc/hazard_ctl.md
Name: hazard_ctl

Overview:
Pipeline hazard controller for the 5-stage rv32 core (fetch/decode/execute/access/writeback). It keeps a registered shadow of destination-register info for the execute, access and writeback stages. From that shadow it produces operand-forwarding selects, load-use stalls, branch/jump flushes and global freeze. It sits beside the per-stage *_ctl blocks and drives the PC and pipeline-register enables.

Parameters:
REG_AW, 5, register-address width (x0..x31)
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
de_valid  in  1  decode stage holds a real instruction
de_rs1  in  REG_AW  decode source register 1
de_rs2  in  REG_AW  decode source register 2
de_use_rs1  in  1  instruction reads rs1
de_use_rs2  in  1  instruction reads rs2
de_rd  in  REG_AW  decode destination register
de_reg_we  in  1  instruction writes rd
de_is_load  in  1  instruction is a load (wb_sel = dmem)
ex_redirect  in  1  taken branch or jump resolved in execute this cycle
mem_stall_req  in  1  dmem not ready; freeze whole pipeline
stall_pc  out  1  hold PC
stall_de  out  1  hold fetch/decode pipeline register
bubble_ex  out  1  load NOP into execute on next edge
flush_de  out  1  squash fetch/decode contents on next edge
fwd_a_sel  out  2  ALU A source: 00 regfile, 01 execute result, 10 access result, 11 writeback data
fwd_b_sel  out  2  same encoding for B / store data

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous and active-high.
- State: three shadow slots E, M, W. Each slot holds {valid, rd, we, is_load}. Reset clears all valid bits; other fields are don't-care.
- Outputs are combinational from slot state plus the de_* inputs and ex_redirect. While rst=1, every output is forced to 0.
- A slot "matches" src s when: slot valid, we=1, rd==s, s!=0, and the corresponding de_use_rsN=1.
- Forward select per operand uses priority E(01) > M(10) > W(11) > 00. The youngest producer wins.
- load_use = de_valid and (E matches rs1 or rs2) and E.is_load.
- Freeze (mem_stall_req=1): stall_pc=stall_de=1; bubble_ex=flush_de=0; all slots hold. Freeze overrides redirect and load_use. A redirect under freeze must be re-presented by execute when unfrozen.
- Redirect (ex_redirect=1, no freeze): flush_de=1, bubble_ex=1, stall_pc=0. The PC takes the ALU target.
- Redirect overrides load_use, because the stalled instruction is squashed anyway.
- Load-use (no freeze, no redirect): stall_pc=stall_de=1, bubble_ex=1. Duration is exactly 1 cycle. On the next cycle the load is in M and forwarding selects 10.
- Slot update each edge, when not frozen: W<=M; M<=E; E<=issue ? {1,de_rd,de_reg_we,de_is_load} : invalid.
- issue = de_valid and not load_use and not ex_redirect.
- de_rd=0 with we=1 is stored but never matches, so x0 is never forwarded.
- Reset asserted mid-stall or mid-flush: state clears on that edge. Outputs are 0 during reset and the cycle after reset shows no hazard.
- Back-to-back loads to the same rd: each load-use evaluation is independent, with no cumulative stall.

Optional Feature:
Macro HAZARD_PERF_EN.
- Defined: adds outputs perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt, each CNT_W bits. They count, respectively, cycles with load_use stall, cycles with ex_redirect flush, and cycles with mem_stall_req. Counters saturate at all-ones and reset to 0.
- Undefined: no ports and no counter logic.

Decomposition:
- Shared package: forward-select encoding constants (FWD_REG, FWD_EX, FWD_ACC, FWD_WB) and the shadow-slot struct/field widths. The forwarding mux in the datapath uses the same package.
- One natural sub-module: hazard_fwd_sel, a combinational priority compare for a single operand, instantiated twice (A and B).

Test Plan:
- add x5 issued, then next cycle add x6 using rs1=x5 -> fwd_a_sel=01, no stall. One cycle later a consumer of x5 gets 10; two cycles later it gets 11.
- lw x7 in E, decode reads rs2=x7 -> stall_pc=stall_de=bubble_ex=1 for exactly 1 cycle; next cycle fwd_b_sel=10, no stall.
- lw x7 in E and ex_redirect=1 in the same cycle -> flush_de=1, bubble_ex=1, stall_pc=0; next cycle E slot invalid.
- mem_stall_req=1 for 3 cycles with x5 producer in M -> stall_pc=stall_de=1 throughout, fwd select stays 10, slots unchanged. The release cycle resumes normal shifting.
- Producer rd=x0 with we=1, consumer rs1=x0 -> fwd_a_sel=00, no stall even if the producer is a load.
- rst=1 asserted during a load-use stall -> all outputs 0 that cycle. After deassert, the consumer decodes with fwd=00. With HAZARD_PERF_EN defined, all counters read 0.
